// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
//   Registered 32-bit integer ALU for the RV32I datapath. A single shared
//   33-bit adder serves ADD, SUB, SLT and SLTU; the logical ops, PASS-B and
//   XOR bypass it. The result and its status flags are captured together on
//   the rising clock edge, so the flags always describe the result they
//   accompany.
//
// Ports
//   clk         in   1   system clock, rising-edge active
//   rst_n       in   1   asynchronous active-low reset
//   SrcA        in  32   operand A
//   SrcB        in  32   operand B
//   ALUControl  in   3   operation select
//                        000 ADD, 001 SUB, 010 AND, 011 OR,
//                        100 PASS-B, 101 SLT, 110 XOR, 111 SLTU
//   ALUResult   out 32   registered result
//   Zero        out  1   registered, result == 0
//   Negative    out  1   registered, result bit 31
//   Carry       out  1   registered adder carry-out (ADD/SUB only)
//   Overflow    out  1   registered signed overflow (ADD/SUB only)
// ---------------------------------------------------------------------------
module alu_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [2:0]  ALUControl,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic        Negative,
  output logic        Carry,
  output logic        Overflow
);

  logic        subMode;
  logic [31:0] bOperand;
  logic [32:0] adderOut;
  logic [31:0] adderSum;
  logic        adderCarry;
  logic        adderOverflow;
  logic        lessSigned;
  logic        lessUnsigned;

  logic [31:0] nextResult;
  logic        nextCarry;
  logic        nextOverflow;

  // The shared adder runs in subtract mode (B inverted, carry-in of one) for
  // SUB and both compares. Overflow is judged against the operand actually
  // fed into the adder, which covers the add and subtract rules with one
  // expression: same-sign inputs producing an opposite-sign sum.
  always_comb begin
    subMode       = (ALUControl == 3'b001) || (ALUControl == 3'b101) ||
                    (ALUControl == 3'b111);
    bOperand      = subMode ? ~SrcB : SrcB;
    adderOut      = {1'b0, SrcA} + {1'b0, bOperand} + {32'd0, subMode};
    adderSum      = adderOut[31:0];
    adderCarry    = adderOut[32];
    adderOverflow = (SrcA[31] == bOperand[31]) && (adderSum[31] != SrcA[31]);
    lessSigned    = adderSum[31] ^ adderOverflow;
    lessUnsigned  = ~adderCarry;
  end

  // Result select. Carry and overflow only carry meaning for the plain
  // arithmetic ops; the compares use the adder internally but report zero
  // flags so branch logic never sees stale arithmetic status.
  always_comb begin
    nextResult   = 32'd0;
    nextCarry    = 1'b0;
    nextOverflow = 1'b0;
    unique case (ALUControl)
      3'b000: begin
        nextResult   = adderSum;
        nextCarry    = adderCarry;
        nextOverflow = adderOverflow;
      end
      3'b001: begin
        nextResult   = adderSum;
        nextCarry    = adderCarry;
        nextOverflow = adderOverflow;
      end
      3'b010:  nextResult = SrcA & SrcB;
      3'b011:  nextResult = SrcA | SrcB;
      3'b100:  nextResult = SrcB;
      3'b101:  nextResult = {31'd0, lessSigned};
      3'b110:  nextResult = SrcA ^ SrcB;
      3'b111:  nextResult = {31'd0, lessUnsigned};
      default: nextResult = 32'd0;
    endcase
  end

  // Single register stage. Zero and Negative are derived from the value
  // being captured rather than the registered one, so they land on the same
  // edge as the result. Reset leaves a zero result, hence Zero set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUResult <= 32'd0;
      Zero      <= 1'b1;
      Negative  <= 1'b0;
      Carry     <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      ALUResult <= nextResult;
      Zero      <= (nextResult == 32'd0);
      Negative  <= nextResult[31];
      Carry     <= nextCarry;
      Overflow  <= nextOverflow;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// ---------------------------------------------------------------------------
// tb_alu_core
//   Self-checking bench for alu_core. Expected values come from a reference
//   function written with plain integer arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_alu_core;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_PASS = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;

  logic        clk;
  logic        rst_n;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  ALUControl;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Negative;
  logic        Carry;
  logic        Overflow;

  int compared;
  int mismatched;

  logic [31:0] expResult;
  logic        expZero;
  logic        expNegative;
  logic        expCarry;
  logic        expOverflow;

  alu_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .Negative   (Negative),
    .Carry      (Carry),
    .Overflow   (Overflow)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: arithmetic done in 64-bit integers, compares done with
  // the language's own signed/unsigned comparison.
  task automatic refModel(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] r,
                          output logic c, output logic v);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    longint wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = 32'd0;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      OP_ADD: begin
        wide = ua + ub;
        r    = wide[31:0];
        c    = (wide >= 64'sd4294967296);
        wide = sa + sb;
        v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      OP_SUB: begin
        wide = ua - ub;
        r    = wide[31:0];
        c    = (ua >= ub);
        wide = sa - sb;
        v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_PASS: r = b;
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      OP_XOR:  r = a ^ b;
      default: r = (ua < ub) ? 32'd1 : 32'd0;
    endcase
  endtask

  // One immediate assertion per compared field.
  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".result"},   ALUResult,          expResult);
    checkValue({tag, ".zero"},     {31'd0, Zero},      {31'd0, expZero});
    checkValue({tag, ".negative"}, {31'd0, Negative},  {31'd0, expNegative});
    checkValue({tag, ".carry"},    {31'd0, Carry},     {31'd0, expCarry});
    checkValue({tag, ".overflow"}, {31'd0, Overflow},  {31'd0, expOverflow});
  endtask

  task automatic setResetExpect();
    expResult   = 32'd0;
    expZero     = 1'b1;
    expNegative = 1'b0;
    expCarry    = 1'b0;
    expOverflow = 1'b0;
  endtask

  // Drive an op on the falling edge, confirm the previous result is still
  // held, then check the new result one rising edge later.
  task automatic applyStimulus(input string tag, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        c;
    logic        v;
    @(negedge clk);
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    #1;
    checkOutput({tag, ".hold"});
    refModel(op, a, b, r, c, v);
    expResult   = r;
    expZero     = (r == 32'd0);
    expNegative = r[31];
    expCarry    = c;
    expOverflow = v;
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] special [6];
    special = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000,
                32'h80000001};
    if ($urandom_range(3) == 0) return special[$urandom_range(5)];
    return $urandom;
  endfunction

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    SrcA       = 32'd0;
    SrcB       = 32'd0;
    ALUControl = OP_ADD;
    setResetExpect();

    // Reset held across edges
    repeat (2) @(posedge clk);
    #1;
    checkOutput("por");
    #1 rst_n = 1'b1;

    // Directed arithmetic cases
    applyStimulus("add_11_22", OP_ADD, 32'h11, 32'h22);
    checkValue("add_11_22.const", ALUResult, 32'h33);
    applyStimulus("sub_ff_f0", OP_SUB, 32'hFF, 32'hF0);
    checkValue("sub_ff_f0.const", ALUResult, 32'h0000000F);
    checkValue("sub_ff_f0.carry1", {31'd0, Carry}, 32'd1);
    applyStimulus("sub_5_5", OP_SUB, 32'd5, 32'd5);
    checkValue("sub_5_5.zero1", {31'd0, Zero}, 32'd1);
    applyStimulus("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h1);
    checkValue("add_wrap.carry1", {31'd0, Carry}, 32'd1);
    applyStimulus("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1);
    checkValue("add_ovf.const", ALUResult, 32'h80000000);
    checkValue("add_ovf.ovf1", {31'd0, Overflow}, 32'd1);

    // Asynchronous reset between edges, held across an edge
    #2 rst_n = 1'b0;
    #1;
    setResetExpect();
    checkOutput("rst_async");
    @(posedge clk);
    #1;
    checkOutput("rst_held");
    #1 rst_n = 1'b1;
    applyStimulus("rel_add", OP_ADD, 32'h11, 32'h22);
    checkValue("rel_add.const", ALUResult, 32'h33);

    // Logical and pass ops
    applyStimulus("and", OP_AND, 32'hFF, 32'hF0F);
    checkValue("and.const", ALUResult, 32'h0000000F);
    applyStimulus("or", OP_OR, 32'hFF, 32'hF0F);
    checkValue("or.const", ALUResult, 32'h00000FFF);
    applyStimulus("xor", OP_XOR, 32'hFF, 32'hF0F);
    checkValue("xor.const", ALUResult, 32'h00000FF0);
    applyStimulus("pass", OP_PASS, 32'hFF, 32'hF0F0F0F0);
    checkValue("pass.const", ALUResult, 32'hF0F0F0F0);

    // Compares
    applyStimulus("slt_2_1", OP_SLT, 32'd2, 32'd1);
    applyStimulus("slt_1_neg", OP_SLT, 32'd1, 32'hF0F00002);
    applyStimulus("slt_neg_1", OP_SLT, 32'hF0F00002, 32'd1);
    checkValue("slt_neg_1.const", ALUResult, 32'd1);
    applyStimulus("slt_min_max", OP_SLT, 32'h80000000, 32'h7FFFFFFF);
    checkValue("slt_min_max.const", ALUResult, 32'd1);
    applyStimulus("sltu_1_big", OP_SLTU, 32'd1, 32'hF0F00002);
    checkValue("sltu_1_big.const", ALUResult, 32'd1);
    applyStimulus("sltu_big_1", OP_SLTU, 32'hF0F00002, 32'd1);
    applyStimulus("sltu_7_7", OP_SLTU, 32'd7, 32'd7);

    // Back-to-back: every op once, consecutive cycles
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("b2b_%0d", i), 3'(i), pickOperand(),
                    pickOperand());
    end

    // Randomized sweep
    for (int i = 0; i < 300; i++) begin
      applyStimulus($sformatf("rnd_%0d", i), 3'($urandom_range(7)),
                    pickOperand(), pickOperand());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared,
             mismatched);
    $finish;
  end

endmodule
